// File: rtl/instruction_memory_loader_pkg.sv
// Shared definitions for the instruction memory loader: byte width and loader FSM states.
package instruction_memory_loader_pkg;

    localparam int BYTE_SIZE = 8;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } loader_state_t;

endpackage

// File: rtl/instruction_memory_loader_byte_assembler.sv
// Collects MSB-first program bytes into instruction words; o_word_valid is high on the
// cycle whose rising edge accepts the final byte of a word.
module byte_assembler
    import instruction_memory_loader_pkg::*;
#(
    parameter  int WORD_SIZE_IN_BYTES = 4,
    localparam int WORD_BITS          = WORD_SIZE_IN_BYTES * BYTE_SIZE,
    localparam int IDX_BITS           = $clog2(WORD_SIZE_IN_BYTES)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_byte_valid,
    input  logic [BYTE_SIZE-1:0] i_byte,
    input  logic                 i_enable,
    output logic [WORD_BITS-1:0] o_word,
    output logic                 o_word_valid
);

    logic [IDX_BITS-1:0]            idx_q;
    logic [WORD_BITS-BYTE_SIZE-1:0] shreg_q;
    logic                           accept;
    logic [WORD_BITS-1:0]           word_c;

    // Clear wins over a simultaneous byte, so the byte is never accepted.
    assign accept = i_byte_valid & i_enable & ~i_clear;
    assign word_c = {shreg_q, i_byte};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            idx_q   <= '0;
            shreg_q <= '0;
        end else if (i_clear) begin
            idx_q   <= '0;
        end else if (accept) begin
            idx_q   <= idx_q + IDX_BITS'(1);
            shreg_q <= word_c[WORD_BITS-BYTE_SIZE-1:0];
        end
    end

    assign o_word       = word_c;
    assign o_word_valid = accept & (idx_q == IDX_BITS'(WORD_SIZE_IN_BYTES - 1));

endmodule

// File: rtl/instruction_memory_loader.sv
// IF-stage instruction memory loaded from a byte stream, with masked PC reads.
// Optional o_misaligned output enabled by defining INSTRUCTION_MEMORY_MISALIGN_CHECK_EN.
//
// state   | meaning
// ST_LOAD | accepting program bytes, o_byte_ready=1
// ST_FULL | all words loaded, bytes ignored until clear or reset
module instruction_memory_loader
    import instruction_memory_loader_pkg::*;
#(
    parameter  int WORD_SIZE_IN_BYTES = 4,
    parameter  int MEM_SIZE_IN_WORDS  = 64,
    localparam int POINTER_SIZE       = $clog2(MEM_SIZE_IN_WORDS * WORD_SIZE_IN_BYTES),
    localparam int COUNT_SIZE         = $clog2(MEM_SIZE_IN_WORDS + 1),
    localparam int WORD_BITS          = WORD_SIZE_IN_BYTES * BYTE_SIZE
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clear,
    input  logic                    i_byte_valid,
    input  logic [BYTE_SIZE-1:0]    i_byte,
    output logic                    o_byte_ready,
    input  logic [POINTER_SIZE-1:0] i_pc,
    output logic [WORD_BITS-1:0]    o_instruction,
    output logic                    o_empty,
    output logic                    o_full,
`ifdef INSTRUCTION_MEMORY_MISALIGN_CHECK_EN
    output logic                    o_misaligned,
`endif
    output logic [COUNT_SIZE-1:0]   o_word_count
);

    localparam int OFFSET_BITS = $clog2(WORD_SIZE_IN_BYTES);
    localparam int INDEX_BITS  = POINTER_SIZE - OFFSET_BITS;
    localparam int PTR_BITS    = $clog2(MEM_SIZE_IN_WORDS);

    loader_state_t          state_q, state_d;
    logic [WORD_BITS-1:0]   mem_q [MEM_SIZE_IN_WORDS];
    logic [PTR_BITS-1:0]    wr_ptr_q;
    logic [COUNT_SIZE-1:0]  count_q;
    logic [WORD_BITS-1:0]   asm_word;
    logic                   asm_word_valid;
    logic                   last_word;
    logic [INDEX_BITS-1:0]  rd_index;
    logic                   rd_hit;

    byte_assembler #(
        .WORD_SIZE_IN_BYTES(WORD_SIZE_IN_BYTES)
    ) u_byte_assembler (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (i_clear),
        .i_byte_valid(i_byte_valid),
        .i_byte      (i_byte),
        .i_enable    (o_byte_ready),
        .o_word      (asm_word),
        .o_word_valid(asm_word_valid)
    );

    assign last_word = (wr_ptr_q == PTR_BITS'(MEM_SIZE_IN_WORDS - 1));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        o_byte_ready = 1'b0;
        case (state_q)
            ST_LOAD: begin
                o_byte_ready = 1'b1;
                if (!i_clear && asm_word_valid && last_word) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (i_clear) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Clear leaves the array untouched; stale words are hidden by the count mask.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < MEM_SIZE_IN_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_clear) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (asm_word_valid) begin
            mem_q[wr_ptr_q] <= asm_word;
            wr_ptr_q        <= wr_ptr_q + PTR_BITS'(1);
            count_q         <= count_q + COUNT_SIZE'(1);
        end
    end

    assign rd_index = i_pc[POINTER_SIZE-1:OFFSET_BITS];
    assign rd_hit   = (32'(rd_index) < 32'(count_q));

`ifdef INSTRUCTION_MEMORY_MISALIGN_CHECK_EN
    assign o_misaligned  = |i_pc[OFFSET_BITS-1:0];
    assign o_instruction = (rd_hit && !o_misaligned) ? mem_q[rd_index[PTR_BITS-1:0]] : '0;
`else
    logic unused_pc_low;
    assign unused_pc_low = ^i_pc[OFFSET_BITS-1:0];
    assign o_instruction = rd_hit ? mem_q[rd_index[PTR_BITS-1:0]] : '0;
`endif

    assign o_word_count = count_q;
    assign o_empty      = (count_q == '0);
    assign o_full       = (count_q == COUNT_SIZE'(MEM_SIZE_IN_WORDS));

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Bench for instruction_memory_loader (4-byte words, 4-word depth): directed scenarios with
// literal expectations plus random traffic, all checked every cycle against a word-list model.
module tb_instruction_memory_loader;

    localparam int W  = 4;
    localparam int M  = 4;
    localparam int PW = $clog2(M * W);
    localparam int CW = $clog2(M + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_clear = 1'b0;
    logic          i_byte_valid = 1'b0;
    logic [7:0]    i_byte = '0;
    logic          o_byte_ready;
    logic [PW-1:0] i_pc = '0;
    logic [31:0]   o_instruction;
    logic          o_empty;
    logic          o_full;
    logic [CW-1:0] o_word_count;
`ifdef INSTRUCTION_MEMORY_MISALIGN_CHECK_EN
    logic          o_misaligned;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    instruction_memory_loader #(
        .WORD_SIZE_IN_BYTES(W),
        .MEM_SIZE_IN_WORDS (M)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_clear      (i_clear),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .i_pc         (i_pc),
        .o_instruction(o_instruction),
        .o_empty      (o_empty),
        .o_full       (o_full),
`ifdef INSTRUCTION_MEMORY_MISALIGN_CHECK_EN
        .o_misaligned (o_misaligned),
`endif
        .o_word_count (o_word_count)
    );

    always #5 clk = ~clk;

    // Model: list of completed words plus the bytes of the word in progress.
    logic [31:0] m_mem [M];
    int          m_count;
    int          m_nb;
    logic [31:0] m_part;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < M; i++) m_mem[i] = '0;
            m_count = 0;
            m_nb    = 0;
            m_part  = '0;
        end else if (i_clear) begin
            m_count = 0;
            m_nb    = 0;
        end else if (i_byte_valid && m_count < M) begin
            m_part = (m_part << 8) | 32'(i_byte);
            m_nb   = m_nb + 1;
            if (m_nb == W) begin
                m_mem[m_count] = m_part;
                m_count        = m_count + 1;
                m_nb           = 0;
            end
        end
    end

    function automatic logic [31:0] model_instr(input int pc);
        int idx;
        idx = pc / W;
`ifdef INSTRUCTION_MEMORY_MISALIGN_CHECK_EN
        if (pc % W != 0) return 32'h0;
`endif
        return (idx < m_count) ? m_mem[idx] : 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 32'(o_byte_ready), 32'(m_count < M));
            check("empty", 32'(o_empty), 32'(m_count == 0));
            check("full", 32'(o_full), 32'(m_count == M));
            check("count", 32'(o_word_count), 32'(m_count));
            check("instr", o_instruction, model_instr(int'(i_pc)));
`ifdef INSTRUCTION_MEMORY_MISALIGN_CHECK_EN
            check("misaligned", 32'(o_misaligned), 32'(int'(i_pc) % W != 0));
`endif
        end
    end

    task automatic drive(input logic v, input logic [7:0] b, input logic c);
        i_byte_valid = v;
        i_byte       = b;
        i_clear      = c;
        @(posedge clk);
        #1;
        i_byte_valid = 1'b0;
        i_clear      = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] w);
        for (int k = 0; k < W; k++) drive(1'b1, w[31-8*k -: 8], 1'b0);
    endtask

    task automatic read_lit(input string name, input int pc, input logic [31:0] exp);
        i_pc = PW'(pc);
        #1;
        check(name, o_instruction, exp);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", 32'(o_byte_ready), 32'd1);
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_count", 32'(o_word_count), 32'd0);
        check("rst_instr", o_instruction, 32'd0);
    endtask

    logic [31:0] words [4] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};

    initial begin
        #2;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // reset in the middle of a word
        drive(1'b1, 8'hEE, 1'b0);
        drive(1'b1, 8'hFF, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load_word(32'h01020304);
        read_lit("first_word", 0, 32'h01020304);
        check("first_count", 32'(o_word_count), 32'd1);
        read_lit("unloaded_pc4", 4, 32'h0);
        read_lit("unloaded_pc12", 12, 32'h0);
        read_lit("loaded_pc0", 0, 32'h01020304);
`ifdef INSTRUCTION_MEMORY_MISALIGN_CHECK_EN
        read_lit("misaligned_pc2", 2, 32'h0);
        check("misaligned_flag", 32'(o_misaligned), 32'd1);
`else
        read_lit("aligned_pc2", 2, 32'h01020304);
`endif

        // fill to capacity
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) load_word(words[i]);
        for (int i = 0; i < 4; i++) read_lit("full_read", 4 * i, words[i]);
        check("full_flag", 32'(o_full), 32'd1);
        check("full_ready", 32'(o_byte_ready), 32'd0);

        // bytes offered while full are dropped
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h5A, 1'b0);
        check("full_count", 32'(o_word_count), 32'd4);
        read_lit("full_mem0", 0, 32'h11223344);

        // clear discards a partial word and beats a simultaneous byte
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h12, 1'b0);
        drive(1'b1, 8'h34, 1'b0);
        drive(1'b1, 8'h56, 1'b0);
        drive(1'b1, 8'h78, 1'b1);
        check("clr_count", 32'(o_word_count), 32'd0);
        check("clr_empty", 32'(o_empty), 32'd1);
        read_lit("clr_pc0", 0, 32'h0);
        load_word(32'hAABBCCDD);
        read_lit("reload_pc0", 0, 32'hAABBCCDD);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            i_pc = PW'($urandom_range(0, M * W - 1));
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 40) == 0));
            if ($urandom_range(0, 150) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
